axi_master_wb_ctrl: RTL
=======================

AXI_MASTER_WB_CTRL -- requirements
Module: axi_master_wb_ctrl

Interface
REQ-001 Parameter ID_W, 12, AXI ID width.
REQ-002 Parameter DATA_W, 64, W data width; strobe width is DATA_W/8.
REQ-003 One clock; reset is asynchronous and active-high: ports clk, rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 m_axi_awvalid, m_axi_awready  in  1 each  AW handshake observed from the AW stage and slave.
REQ-007 m_axi_awlen  in  8  burst length minus one of the accepted AW.
REQ-008 m_axi_awid  in  ID_W  ID of the accepted AW.
REQ-009 write_valid  in  1  user beat available; wdata in DATA_W; wstrb in DATA_W/8.
REQ-010 write_ready  out  1  user beat accepted this cycle when write_valid is also high.
REQ-011 m_axi_wvalid, m_axi_wlast  out  1 each; m_axi_wdata out DATA_W; m_axi_wstrb out DATA_W/8; m_axi_wid out ID_W.
REQ-012 m_axi_wready  in  1  slave W ready.
REQ-013 m_axi_bvalid  in  1; m_axi_bid in ID_W; m_axi_bresp in 2; m_axi_bready out 1.
REQ-014 tx_wactive, tx_bwait  out  1 each  state flags; tx_awlen out 8 captured length.
REQ-015 aw_idle  out  1  high only in IDLE; AW stage gates new requests with it.
REQ-016 resp_valid  out  1  one-cycle pulse; resp_code out 2; bid_err out 1 (valid with resp_valid).
REQ-017 aw_ovf  out  1  sticky: AW handshake seen outside IDLE.

Function
REQ-018 The block SHALL implement states IDLE, WDATA, BWAIT; aw_fire = m_axi_awvalid & m_axi_awready.
REQ-019 IDLE: on aw_fire, capture awlen into tx_awlen, awid into m_axi_wid, clear 8-bit beat counter, go WDATA next cycle.
REQ-020 WDATA: tx_wactive=1; write_ready = (!m_axi_wvalid | m_axi_wready) & !last_loaded.
REQ-021 On write_valid & write_ready, the block SHALL register wdata/wstrb to m_axi_wdata/wstrb, set m_axi_wvalid, set m_axi_wlast = (beat counter == tx_awlen), increment counter; latency user-accept to W valid = 1 cycle.
REQ-022 last_loaded SHALL set when the wlast beat is loaded and clear on leaving WDATA; no beat beyond tx_awlen+1 is ever accepted.
REQ-023 m_axi_wvalid/wdata/wstrb/wlast SHALL hold stable while m_axi_wvalid & !m_axi_wready (AXI stability rule).
REQ-024 W handshake without new load SHALL clear m_axi_wvalid; simultaneous handshake and load SHALL keep m_axi_wvalid high with new beat (full throughput, one beat/cycle).
REQ-025 Handshake of a beat with m_axi_wlast=1 SHALL move to BWAIT next cycle, clear m_axi_wvalid and m_axi_wlast, set m_axi_bready.
REQ-026 BWAIT: tx_bwait=1, m_axi_bready=1; on m_axi_bvalid, pulse resp_valid with resp_code=m_axi_bresp, bid_err=(m_axi_bid != m_axi_wid), clear m_axi_bready, go IDLE.
REQ-027 m_axi_bvalid in IDLE or WDATA SHALL be ignored (bready low).
REQ-028 aw_fire in WDATA or BWAIT SHALL set aw_ovf and SHALL NOT alter captured length, ID or counter.
REQ-029 awlen=0 SHALL yield a single beat with m_axi_wlast=1; awlen=255 SHALL yield 256 beats, counter compare exact, no wrap.
REQ-030 m_axi_wvalid SHALL never depend combinationally on m_axi_wready.

Reset
REQ-031 Asynchronous rst SHALL force IDLE and zero all outputs and registers: wvalid, wlast, wdata, wstrb, wid, bready, tx_wactive, tx_bwait, tx_awlen, resp_valid, resp_code, bid_err, aw_ovf, counter; aw_idle=1.
REQ-032 rst asserted mid-burst or in BWAIT SHALL abort immediately; after release, block accepts a fresh AW in first cycle.

Verification
REQ-033 awlen=3, id=0x5A, write_valid and wready held high -> 4 beats on consecutive cycles, wlast only on 4th, bready next cycle, bvalid bresp=0 bid=0x5A -> resp_valid 1 cycle, resp_code=0, bid_err=0.
REQ-034 awlen=0 -> single beat wlast=1; bid=0x001 vs id 0x000 -> bid_err=1.
REQ-035 awlen=1, wready low 3 cycles on beat 0 -> wdata/wstrb/wlast stable, write_ready=0, no extra beats.
REQ-036 awlen=255 -> exactly 256 handshakes, wlast on 256th only.
REQ-037 Second aw_fire during WDATA -> aw_ovf=1, burst length unchanged.
REQ-038 rst asserted after beat 2 of awlen=7 -> all outputs 0 asynchronously, aw_idle=1; new AW awlen=0 completes normally.

Source files
------------

// File: rtl/axi_master_wb_ctrl_if.sv
// axi_master_wb_ctrl_if: AW observation, user write beats, AXI W/B channels and status of the W-channel controller.
interface axi_master_wb_ctrl_if #(parameter int ID_W = 12, parameter int DATA_W = 64);
  logic                  m_axi_awvalid, m_axi_awready;
  logic [7:0]            m_axi_awlen;
  logic [ID_W-1:0]       m_axi_awid;
  logic                  write_valid, write_ready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  m_axi_wvalid, m_axi_wlast, m_axi_wready;
  logic [DATA_W-1:0]     m_axi_wdata;
  logic [DATA_W/8-1:0]   m_axi_wstrb;
  logic [ID_W-1:0]       m_axi_wid;
  logic                  m_axi_bvalid, m_axi_bready;
  logic [ID_W-1:0]       m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  tx_wactive, tx_bwait, aw_idle, resp_valid, bid_err, aw_ovf;
  logic [7:0]            tx_awlen;
  logic [1:0]            resp_code;
  modport master (
    input  m_axi_awvalid, m_axi_awready, m_axi_awlen, m_axi_awid,
    input  write_valid, wdata, wstrb, m_axi_wready, m_axi_bvalid, m_axi_bid, m_axi_bresp,
    output write_ready, m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb, m_axi_wid, m_axi_bready,
    output tx_wactive, tx_bwait, tx_awlen, aw_idle, resp_valid, resp_code, bid_err, aw_ovf
  );
  modport slave (
    output m_axi_awvalid, m_axi_awready, m_axi_awlen, m_axi_awid,
    output write_valid, wdata, wstrb, m_axi_wready, m_axi_bvalid, m_axi_bid, m_axi_bresp,
    input  write_ready, m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb, m_axi_wid, m_axi_bready,
    input  tx_wactive, tx_bwait, tx_awlen, aw_idle, resp_valid, resp_code, bid_err, aw_ovf
  );
endinterface

// File: rtl/axi_master_wb_ctrl.sv
// axi_master_wb_ctrl: AXI write-data/response sequencer driven by an observed AW handshake.
module axi_master_wb_ctrl #(
  parameter int ID_W   = 12,
  parameter int DATA_W = 64
) (
  input logic                   clk,
  input logic                   rst,
  axi_master_wb_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, WDATA, BWAIT} state_t;
  state_t              state_q, state_d;
  logic [7:0]          awlen_q, awlen_d, cnt_q, cnt_d;
  logic [ID_W-1:0]     wid_q, wid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                wvalid_q, wvalid_d, wlast_q, wlast_d, last_loaded_q, last_loaded_d;
  logic                resp_valid_q, resp_valid_d, bid_err_q, bid_err_d, aw_ovf_q, aw_ovf_d;
  logic [1:0]          resp_code_q, resp_code_d;
  logic                aw_fire, w_hs, load, is_last;
  assign aw_fire = bus.m_axi_awvalid & bus.m_axi_awready;
  assign w_hs    = wvalid_q & bus.m_axi_wready;
  assign bus.write_ready = (state_q == WDATA) & (!wvalid_q | bus.m_axi_wready) & !last_loaded_q;
  assign load    = bus.write_valid & bus.write_ready;
  assign is_last = cnt_q == awlen_q;
  always_comb begin
    state_d       = state_q;
    awlen_d       = awlen_q;
    cnt_d         = cnt_q;
    wid_d         = wid_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wvalid_d      = wvalid_q;
    wlast_d       = wlast_q;
    last_loaded_d = last_loaded_q;
    resp_valid_d  = 1'b0;
    resp_code_d   = resp_code_q;
    bid_err_d     = bid_err_q;
    aw_ovf_d      = aw_ovf_q | (aw_fire & (state_q != IDLE));
    if (state_q == IDLE && aw_fire) begin
      awlen_d = bus.m_axi_awlen;
      wid_d   = bus.m_axi_awid;
      cnt_d   = 8'd0;
      state_d = WDATA;
    end
    if (w_hs) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
      if (wlast_q) begin
        state_d       = BWAIT;
        last_loaded_d = 1'b0;
      end
    end
    // the counter parks on the final beat so awlen=255 never wraps
    if (load) begin
      wdata_d       = bus.wdata;
      wstrb_d       = bus.wstrb;
      wvalid_d      = 1'b1;
      wlast_d       = is_last;
      last_loaded_d = is_last;
      cnt_d         = is_last ? cnt_q : cnt_q + 8'd1;
    end
    if (state_q == BWAIT && bus.m_axi_bvalid) begin
      resp_valid_d = 1'b1;
      resp_code_d  = bus.m_axi_bresp;
      bid_err_d    = bus.m_axi_bid != wid_q;
      state_d      = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      awlen_q       <= '0;
      cnt_q         <= '0;
      wid_q         <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      last_loaded_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_code_q   <= '0;
      bid_err_q     <= 1'b0;
      aw_ovf_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      awlen_q       <= awlen_d;
      cnt_q         <= cnt_d;
      wid_q         <= wid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wvalid_q      <= wvalid_d;
      wlast_q       <= wlast_d;
      last_loaded_q <= last_loaded_d;
      resp_valid_q  <= resp_valid_d;
      resp_code_q   <= resp_code_d;
      bid_err_q     <= bid_err_d;
      aw_ovf_q      <= aw_ovf_d;
    end
  end
  assign bus.m_axi_wvalid = wvalid_q;
  assign bus.m_axi_wlast  = wlast_q;
  assign bus.m_axi_wdata  = wdata_q;
  assign bus.m_axi_wstrb  = wstrb_q;
  assign bus.m_axi_wid    = wid_q;
  assign bus.m_axi_bready = state_q == BWAIT;
  assign bus.tx_bwait     = state_q == BWAIT;
  assign bus.tx_wactive   = state_q == WDATA;
  assign bus.aw_idle      = state_q == IDLE;
  assign bus.tx_awlen     = awlen_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_code    = resp_code_q;
  assign bus.bid_err      = bid_err_q;
  assign bus.aw_ovf       = aw_ovf_q;
endmodule
